// File: rtl/divby_pkg.sv
// divby_pkg: shared state encoding and constant helpers for the serial
// divisibility engine and its stream scheduler.
package divby_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time width derivation; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/divby_mod_fsm.sv
// divby_mod_fsm: serial MSB-first remainder engine, rem <= (2*rem + din) mod DIVISOR.
// Holds when en=0, clears when clr=1; also used standalone by the divisibility detectors.
module divby_mod_fsm
    import divby_pkg::*;
#(
    parameter  int unsigned DIVISOR = 4,
    localparam int unsigned RW      = clog2(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          din,
    output logic [RW-1:0] rem
);

    logic [RW:0]   dbl;
    logic [RW-1:0] rem_next;

    // Since rem < DIVISOR, 2*rem+din < 2*DIVISOR, so one conditional subtract suffices.
    always_comb begin
        dbl      = {rem, din};
        rem_next = dbl[RW-1:0];
        if (dbl >= (RW+1)'(DIVISOR)) begin
            rem_next = RW'(dbl - (RW+1)'(DIVISOR));
        end
    end

    // Remainder register: clear has priority over shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
        end else if (clr) begin
            rem <= '0;
        end else if (en) begin
            rem <= rem_next;
        end
    end

endmodule

// File: rtl/divby_stream_sched.sv
// divby_stream_sched: arbitrates NREQ word requesters onto one serial
// mod-DIVISOR engine and returns id/remainder/divisible on a valid/ready port.
// DIVBY_RR_ARB_EN selects round-robin arbitration; default is fixed priority
// (lowest asserted index wins).
module divby_stream_sched
    import divby_pkg::*;
#(
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned DIVISOR = 4,
    localparam int unsigned RW      = clog2(DIVISOR),
    localparam int unsigned IDW     = clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output logic [RW-1:0]           res_rem,
    output logic                    res_divisible,
    output logic                    busy
);

    localparam int unsigned CW = clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [IDW-1:0]   grant;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    rem;
    logic [WIDTH-1:0] words [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = req_data[i*WIDTH +: WIDTH];
    end

`ifdef DIVBY_RR_ARB_EN
    logic [IDW-1:0] rr_ptr;
    int unsigned    idx;
    logic           found;

    // Round-robin grant: first asserted requester at or after rr_ptr.
    always_comb begin
        grant = '0;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[IDW'(idx)]) begin
                grant = IDW'(idx);
                found = 1'b1;
            end
        end
    end

    // Pointer moves just past the requester that was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (32'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
        end
    end
`else
    // Fixed-priority grant: lowest asserted index wins.
    always_comb begin
        grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[IDW'(k)]) begin
                grant = IDW'(k);
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, accept and one-hot ready; nothing is accepted while reset is held.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (!rst && (|req_valid)) begin
                    accept           = 1'b1;
                    req_ready[grant] = 1'b1;
                    state_next       = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word capture, MSB-first shifting, bit count and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            cnt       <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            res_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
            if (accept) begin
                sreg   <= words[grant];
                res_id <= grant;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
                cnt  <= cnt + 1'b1;
            end
        end
    end

    divby_mod_fsm #(
        .DIVISOR (DIVISOR)
    ) u_mod_fsm (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == SHIFT),
        .din (sreg[WIDTH-1]),
        .rem (rem)
    );

    // The engine register holds its final value through DONE; the flag is only asserted with a result.
    assign res_rem       = rem;
    assign res_divisible = res_valid & (rem == '0);

endmodule

// File: tb/tb_divby_stream_sched.sv
// tb_divby_stream_sched: drives two schedulers (DIVISOR 4 and 3) with the same
// requests and checks grants, latency and results against an arithmetic model.
module tb_divby_stream_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int RW4   = $clog2(4);
    localparam int RW3   = $clog2(3);
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  res_ready;

    logic [NREQ-1:0] req_ready,  req_ready3;
    logic            res_valid,  res_valid3;
    logic [IDW-1:0]  res_id,     res_id3;
    logic [RW4-1:0]  res_rem;
    logic [RW3-1:0]  res_rem3;
    logic            res_div,    res_div3;
    logic            busy,       busy3;

    int n_vec    = 0;
    int n_err    = 0;
    int rr_model = 0;

    always #5 clk = ~clk;

    divby_stream_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DIVISOR(4)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_rem(res_rem), .res_divisible(res_div), .busy(busy)
    );

    divby_stream_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DIVISOR(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready3), .res_valid(res_valid3), .res_ready(res_ready),
        .res_id(res_id3), .res_rem(res_rem3), .res_divisible(res_div3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] mask);
`ifdef DIVBY_RR_ARB_EN
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(rr_model + k) % NREQ]) return (rr_model + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (mask[k]) return k;
        end
`endif
        return 0;
    endfunction

    // One full transaction: offer mask, expect grant, latency, held result, release.
    task automatic run_word(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] data,
                            input int hold, output int obs_id);
        int g;
        int wi;
        int lat;
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = mask;
        req_data  = data;
        g  = model_grant(mask);
        wi = int'(data[g*WIDTH +: WIDTH]);
        #1;
        chk("req_ready", 32'(req_ready), 32'(1) << g);
        chk("req_ready_d3", 32'(req_ready3), 32'(1) << g);
`ifdef DIVBY_RR_ARB_EN
        rr_model = (g + 1) % NREQ;
`endif
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!res_valid) chk("shift_busy_noready", 32'({busy, |req_ready}), 32'd2);
        end while (!res_valid && lat < 40);
        chk("latency", 32'(lat), 32'(WIDTH + 1));
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_valid_d3", 32'(res_valid3), 32'd1);
            chk("res_id", 32'(res_id), 32'(g));
            chk("res_id_d3", 32'(res_id3), 32'(g));
            chk("res_rem", 32'(res_rem), 32'(wi % 4));
            chk("res_div", 32'(res_div), 32'((wi % 4) == 0));
            chk("res_rem_d3", 32'(res_rem3), 32'(wi % 3));
            chk("res_div_d3", 32'(res_div3), 32'((wi % 3) == 0));
            chk("done_busy_noready", 32'({busy, |req_ready}), 32'd2);
        end
        obs_id    = int'(res_id);
        res_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("release", 32'({res_valid, res_valid3, busy, busy3}), 32'd0);
        res_ready = 1'b0;
    endtask

    // Reset in the middle of shifting must discard the word without a result.
    task automatic rst_mid_shift(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] data);
        int seen;
        seen = 0;
        @(negedge clk);
        req_valid = mask;
        req_data  = data;
        res_ready = 1'b1;
        #1;
        chk("rst_pre_accept", 32'(|req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("rst_in_shift", 32'(busy), 32'd1);
        rst       = 1'b1;
        req_valid = mask;
        @(negedge clk);
        chk("rst_outputs", 32'({res_valid, res_id, res_rem, res_div, busy}), 32'd0);
        chk("rst_ready", 32'({req_ready, req_ready3}), 32'd0);
        rst       = 1'b0;
        req_valid = '0;
        rr_model  = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid || res_valid3 || busy) seen++;
        end
        chk("rst_no_result", 32'(seen), 32'd0);
        res_ready = 1'b0;
    endtask

    initial begin
        int id;
        int seq [5];
        logic [NREQ-1:0]       mask;
        logic [NREQ*WIDTH-1:0] data;
        logic [WIDTH-1:0]      w;
`ifdef DIVBY_RR_ARB_EN
        seq = '{0, 1, 2, 3, 0};
`else
        seq = '{0, 0, 0, 0, 0};
`endif
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        req_valid = '1;
        #1;
        chk("reset_ready", 32'({req_ready, req_ready3}), 32'd0);
        chk("reset_outputs", 32'({res_valid, res_id, res_rem, res_div, busy}), 32'd0);
        chk("reset_outputs_d3", 32'({res_valid3, res_id3, res_rem3, res_div3, busy3}), 32'd0);
        rst       = 1'b0;
        req_valid = '0;

        run_word(4'b0001, 32'h0000_000C, 0, id);
        run_word(4'b0100, 32'h00FF_0000, 0, id);
        run_word(4'b0010, 32'h0000_0000, 0, id);
        rst_mid_shift(4'b0001, 32'h0000_00A5);

        for (int i = 0; i < 5; i++) begin
            run_word(4'b1111, 32'h4433_2211, 0, id);
            chk("grant_order", 32'(id), 32'(seq[i]));
        end

        run_word(4'b1000, 32'h7F00_0000, 5, id);
        run_word(4'b0001, 32'h0000_002D, 0, id);
        run_word(4'b0001, 32'h0000_002E, 0, id);

        for (int n = 0; n < 40; n++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 4))
                    0:       w = '0;
                    1:       w = '1;
                    default: w = WIDTH'($urandom);
                endcase
                data[i*WIDTH +: WIDTH] = w;
            end
            run_word(mask, data, int'($urandom_range(0, 3)), id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
